button_gesture_ctrl: RTL and testbench

Gesture classifier that sits downstream of the per-button debouncer and drives the UI/command logic. It consumes one debounced, already-synchronous button level and classifies each press as a single click, double click or long press. Results are reported as one-cycle event pulses plus a held-level flag. One instance is used per button.

---
 rtl/button_gesture_ctrl.sv | 140 ++++++++++++++
 tb/tb_button_gesture_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture_ctrl.sv
// Classifies each debounced button press as single click, double click or long press.
// Events are one-cycle registered pulses; o_held tracks a long press that is still down.
module button_gesture_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int LONG_CYCLES = 1000,
    parameter int GAP_CYCLES  = 400
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_btn,
    input  logic       i_enable,
    output logic       o_click,
    output logic       o_dclick,
    output logic       o_long,
    output logic       o_held,
    output logic       o_busy,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4,
        WAIT_REL  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_TC = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_TC  = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 btn_q_reg;
    logic                 click_reg, click_next;
    logic                 dclick_reg, dclick_next;
    logic                 long_reg, long_next;
    logic                 held_reg, held_next;
    logic                 rise;

    // btn_q comes out of reset high so a button held through reset needs a fresh press.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            btn_q_reg  <= 1'b1;
            click_reg  <= 1'b0;
            dclick_reg <= 1'b0;
            long_reg   <= 1'b0;
            held_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            btn_q_reg  <= i_btn;
            click_reg  <= click_next;
            dclick_reg <= dclick_next;
            long_reg   <= long_next;
            held_reg   <= held_next;
        end
    end

    assign rise = i_btn & ~btn_q_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        click_next  = 1'b0;
        dclick_next = 1'b0;
        long_next   = 1'b0;
        if (!i_enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (rise) state_next = PRESS1;
                end
                PRESS1: begin
                    if (!i_btn) begin
                        state_next = WAIT_GAP;
                        cnt_next   = '0;
                    end else if (cnt_reg == LONG_TC) begin
                        state_next = LONG_HELD;
                        long_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                WAIT_GAP: begin
                    // A rise on the terminal count still counts as the second press.
                    if (rise) begin
                        state_next = PRESS2;
                        cnt_next   = '0;
                    end else if (cnt_reg == GAP_TC) begin
                        state_next = IDLE;
                        click_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                PRESS2: begin
                    if (!i_btn) begin
                        state_next  = IDLE;
                        dclick_next = 1'b1;
                        cnt_next    = '0;
                    end else if (cnt_reg == LONG_TC) begin
                        state_next  = WAIT_REL;
                        dclick_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                LONG_HELD: begin
                    if (!i_btn) state_next = IDLE;
                end
                WAIT_REL: begin
                    if (!i_btn) state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
        held_next = (state_next == LONG_HELD);
    end

    assign o_click  = click_reg;
    assign o_dclick = dclick_reg;
    assign o_long   = long_reg;
    assign o_held   = held_reg;
    assign o_busy   = (state_reg != IDLE);
    assign o_state  = state_reg;

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Self-checking bench for button_gesture_ctrl: vector table, directed corner cases,
// then random button traffic against a timestamp-based gesture model.
module tb_button_gesture_ctrl;

    localparam int L = 16;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn = 1'b0;
    logic       en = 1'b1;
    logic       o_click, o_dclick, o_long, o_held, o_busy;
    logic [2:0] o_state;

    int passed = 0;
    int total  = 0;

    button_gesture_ctrl #(
        .CNT_WIDTH  (16),
        .LONG_CYCLES(L),
        .GAP_CYCLES (G)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_btn   (btn),
        .i_enable(en),
        .o_click (o_click),
        .o_dclick(o_dclick),
        .o_long  (o_long),
        .o_held  (o_held),
        .o_busy  (o_busy),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       e;
        logic       r;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic b, input logic e, input logic r, input logic c,
                                input logic d, input logic l, input logic h, input logic [2:0] st);
        vec_t v;
        v.b = b;
        v.e = e;
        v.r = r;
        v.exp = {c, d, l, h, (st != 3'd0), st};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic b, input logic e, input logic r);
        btn  = b;
        en   = e;
        rstn = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic c, input logic d, input logic l,
                           input logic h, input logic [2:0] st);
        check(name, {o_click, o_dclick, o_long, o_held, o_busy, o_state},
              {c, d, l, h, (st != 3'd0), st});
    endtask

    // Gesture model: remembers the edge numbers of the accepted press/release events
    // and decides outcomes by elapsed-edge arithmetic.
    int   m_n;
    int   g_start, g_rel, g_p2, g_hold;
    logic m_prev;

    function automatic void m_clear();
        g_start = -1;
        g_rel   = -1;
        g_p2    = -1;
        g_hold  = 0;
    endfunction

    function automatic logic [4:0] model_edge(input logic b, input logic e, input logic r);
        logic rs, c, d, l;
        c = 1'b0;
        d = 1'b0;
        l = 1'b0;
        m_n++;
        if (!r) begin
            m_clear();
            m_prev = 1'b1;
            return 5'b0;
        end
        rs = b & ~m_prev;
        m_prev = b;
        if (!e) m_clear();
        else if (g_hold != 0) begin
            if (!b) m_clear();
        end else if (g_start < 0) begin
            if (rs) g_start = m_n;
        end else if (g_rel < 0) begin
            if (!b) g_rel = m_n;
            else if (m_n - g_start == L) begin
                l = 1'b1;
                g_hold = 1;
            end
        end else if (g_p2 < 0) begin
            if (rs) g_p2 = m_n;
            else if (m_n - g_rel == G) begin
                c = 1'b1;
                m_clear();
            end
        end else begin
            if (!b) begin
                d = 1'b1;
                m_clear();
            end else if (m_n - g_p2 == L) begin
                d = 1'b1;
                g_hold = 2;
            end
        end
        return {c, d, l, (g_hold == 1), (g_start >= 0)};
    endfunction

    initial begin
        logic       cur, rb, re, rr;
        int         run;
        logic [4:0] exp5;

        // Vector table: reset, single click, double click, long press.
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 0, 0, 0, 2);
        add(0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) add(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1, 1, 4);
        for (int i = 0; i < 23; i++) add(1, 1, 1, 0, 0, 0, 1, 4);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].e, tbl[i].r);
            check($sformatf("table[%0d]", i),
                  {o_click, o_dclick, o_long, o_held, o_busy, o_state}, tbl[i].exp);
        end

        // Release on the same edge as the long threshold: click path, no o_long.
        step(1, 1, 1);
        chk_out("thr_enter", 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 1);
            chk_out("thr_hold", 0, 0, 0, 0, 1);
        end
        step(0, 1, 1);
        chk_out("thr_release", 0, 0, 0, 0, 2);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1);
            chk_out("thr_gap", 0, 0, 0, 0, 2);
        end
        step(0, 1, 1);
        chk_out("thr_click", 1, 0, 0, 0, 0);

        // Second rise exactly at the gap terminal count.
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        chk_out("gap_tc_wait", 0, 0, 0, 0, 2);
        step(1, 1, 1);
        chk_out("gap_tc_rise", 0, 0, 0, 0, 3);
        step(0, 1, 1);
        chk_out("gap_tc_dclick", 0, 1, 0, 0, 0);

        // Second press held 30 cycles.
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        for (int i = 0; i < 2; i++) step(0, 1, 1);
        step(1, 1, 1);
        chk_out("p2_enter", 0, 0, 0, 0, 3);
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 1);
            chk_out("p2_hold", 0, 0, 0, 0, 3);
        end
        step(1, 1, 1);
        chk_out("p2_dclick", 0, 1, 0, 0, 5);
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 1);
            chk_out("p2_wait_rel", 0, 0, 0, 0, 5);
        end
        step(0, 1, 1);
        chk_out("p2_release", 0, 0, 0, 0, 0);

        // Held through reset, disable mid-PRESS1, reset mid-WAIT_GAP.
        step(1, 1, 0);
        step(1, 1, 0);
        chk_out("rst_held", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1);
            chk_out("held_thru_rst", 0, 0, 0, 0, 0);
        end
        step(0, 1, 1);
        step(1, 1, 1);
        chk_out("new_press", 0, 0, 0, 0, 1);
        step(1, 1, 1);
        step(1, 0, 1);
        chk_out("disable_p1", 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1);
            chk_out("after_disable", 0, 0, 0, 0, 0);
        end
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        chk_out("pre_rst_gap", 0, 0, 0, 0, 2);
        step(0, 1, 0);
        chk_out("rst_gap", 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1);
            chk_out("after_rst", 0, 0, 0, 0, 0);
        end

        // Random traffic against the model.
        m_n    = 0;
        m_prev = 1'b1;
        m_clear();
        rb = 1'($urandom_range(0, 1));
        step(rb, 1, 0);
        exp5 = model_edge(rb, 1, 0);
        cur = 1'b0;
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                cur = ~cur;
                run = $urandom_range(1, 24);
            end
            run--;
            rb = cur;
            re = ($urandom_range(0, 99) != 0);
            rr = ($urandom_range(0, 299) != 0);
            step(rb, re, rr);
            exp5 = model_edge(rb, re, rr);
            check($sformatf("rand[%0d]", i), {o_click, o_dclick, o_long, o_held, o_busy}, exp5);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
